// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
//  state_t       : controller FSM state (IDLE, RUN, MISS)
//  hazard_ctrl_t : the six PC / pipeline-register control outputs bundled together
//  REG_AW, CNT_W : default register-address and perf-counter widths
package hazard_pkg;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_MISS = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_stall;
    logic pc_enable;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_stall;
  } hazard_ctrl_t;

  // Core held idle: PC frozen, IF/ID zeroed, NOP fed into ID/EX.
  localparam hazard_ctrl_t CTRL_IDLE = '{
    pc_stall: 1'b0, pc_enable: 1'b0, ifid_write: 1'b0,
    ifid_flush: 1'b1, idex_bubble: 1'b1, pipe_stall: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard perf counters.
//  clk_i : clock
//  rst_i : synchronous active-high clear
//  inc_i : add one this cycle (ignored once the count is all-ones)
//  cnt_o : current count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage core: turns dcache-miss, taken-branch
// and load-use events into PC and IF/ID / ID/EX register controls, and
// counts each event in a saturating perf counter.
//  clk_i, rst_i        : clock, synchronous active-high reset
//  start_i             : core run enable (0 forces IDLE)
//  mem_stall_i         : dcache miss in progress
//  branch_taken_i      : branch in EX resolved taken
//  idex_memread_i      : ID/EX holds a load
//  idex_rt_i           : load destination register
//  ifid_rs_i/ifid_rt_i : IF/ID source registers
//  pc_stall_o, pc_enable_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
//  pipe_stall_o        : PC / pipeline controls (combinational)
//  lu_cnt_o, flush_cnt_o, miss_cyc_o : perf counters
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = hazard_pkg::REG_AW,
  parameter int CNT_W  = hazard_pkg::CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              mem_stall_i,
  input  logic              branch_taken_i,
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rt_i,
  input  logic [REG_AW-1:0] ifid_rs_i,
  input  logic [REG_AW-1:0] ifid_rt_i,
  output logic              pc_stall_o,
  output logic              pc_enable_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              pipe_stall_o,
  output logic [CNT_W-1:0]  lu_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic [CNT_W-1:0]  miss_cyc_o
);

  state_t       r_state;
  state_t       w_state_next;
  hazard_ctrl_t w_ctrl;
  logic         w_load_use;
  logic         w_rule_miss;
  logic         w_rule_branch;
  logic         w_rule_lu;
  logic [2:0]   w_inc;
  logic [CNT_W-1:0] w_cnt [3];

  // r0 is hard-wired zero, so a load "into" it never creates a dependency.
  assign w_load_use = idex_memread_i && (idex_rt_i != '0) &&
                      ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

  // Priority encoder: miss > branch > load-use > normal advance.
  always_comb begin
    w_ctrl        = CTRL_IDLE;
    w_rule_miss   = 1'b0;
    w_rule_branch = 1'b0;
    w_rule_lu     = 1'b0;
    if (r_state != ST_IDLE) begin
      if (mem_stall_i) begin
        // Everything frozen; branch / load-use get re-evaluated after the miss.
        w_rule_miss = 1'b1;
        w_ctrl      = '{pc_stall: 1'b1, pc_enable: 1'b0, ifid_write: 1'b0,
                        ifid_flush: 1'b0, idex_bubble: 1'b0, pipe_stall: 1'b1};
      end else if (branch_taken_i) begin
        w_rule_branch = 1'b1;
        w_ctrl        = '{pc_stall: 1'b0, pc_enable: 1'b1, ifid_write: 1'b1,
                          ifid_flush: 1'b1, idex_bubble: 1'b1, pipe_stall: 1'b0};
      end else if (w_load_use) begin
        w_rule_lu = 1'b1;
        w_ctrl    = '{pc_stall: 1'b0, pc_enable: 1'b0, ifid_write: 1'b0,
                      ifid_flush: 1'b0, idex_bubble: 1'b1, pipe_stall: 1'b0};
      end else begin
        w_ctrl = '{pc_stall: 1'b0, pc_enable: 1'b1, ifid_write: 1'b1,
                   ifid_flush: 1'b0, idex_bubble: 1'b0, pipe_stall: 1'b0};
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (!start_i) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_next = ST_RUN;
        ST_RUN:  w_state_next = mem_stall_i ? ST_MISS : ST_RUN;
        ST_MISS: w_state_next = mem_stall_i ? ST_MISS : ST_RUN;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Counter order: 0 = load-use, 1 = branch flush, 2 = miss cycles.
  assign w_inc = {3{start_i}} & {w_rule_miss, w_rule_branch, w_rule_lu};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_inc[gi]),
        .cnt_o (w_cnt[gi])
      );
    end
  endgenerate

  assign lu_cnt_o      = w_cnt[0];
  assign flush_cnt_o   = w_cnt[1];
  assign miss_cyc_o    = w_cnt[2];

  assign pc_stall_o    = w_ctrl.pc_stall;
  assign pc_enable_o   = w_ctrl.pc_enable;
  assign ifid_write_o  = w_ctrl.ifid_write;
  assign ifid_flush_o  = w_ctrl.ifid_flush;
  assign idex_bubble_o = w_ctrl.idex_bubble;
  assign pipe_stall_o  = w_ctrl.pipe_stall;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a CNT_W=16 instance for function
// checks and a CNT_W=4 instance (same stimulus) for counter saturation.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mem_stall = 1'b0;
  logic       branch = 1'b0;
  logic       memread = 1'b0;
  logic [4:0] idex_rt = '0;
  logic [4:0] ifid_rs = '0;
  logic [4:0] ifid_rt = '0;

  logic        pc_stall, pc_enable, ifid_write, ifid_flush, idex_bubble, pipe_stall;
  logic [15:0] lu_cnt, flush_cnt, miss_cyc;
  logic        s_pc_stall, s_pc_enable, s_ifid_write, s_ifid_flush, s_idex_bubble, s_pipe_stall;
  logic [3:0]  s_lu_cnt, s_flush_cnt, s_miss_cyc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mem_stall_i(mem_stall),
    .branch_taken_i(branch), .idex_memread_i(memread), .idex_rt_i(idex_rt),
    .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt),
    .pc_stall_o(pc_stall), .pc_enable_o(pc_enable), .ifid_write_o(ifid_write),
    .ifid_flush_o(ifid_flush), .idex_bubble_o(idex_bubble), .pipe_stall_o(pipe_stall),
    .lu_cnt_o(lu_cnt), .flush_cnt_o(flush_cnt), .miss_cyc_o(miss_cyc)
  );

  pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(4)) dut_small (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mem_stall_i(mem_stall),
    .branch_taken_i(branch), .idex_memread_i(memread), .idex_rt_i(idex_rt),
    .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt),
    .pc_stall_o(s_pc_stall), .pc_enable_o(s_pc_enable), .ifid_write_o(s_ifid_write),
    .ifid_flush_o(s_ifid_flush), .idex_bubble_o(s_idex_bubble), .pipe_stall_o(s_pipe_stall),
    .lu_cnt_o(s_lu_cnt), .flush_cnt_o(s_flush_cnt), .miss_cyc_o(s_miss_cyc)
  );

  // Packed view {pc_stall, pc_enable, ifid_write, ifid_flush, idex_bubble, pipe_stall}
  function automatic logic [5:0] ctrl();
    return {pc_stall, pc_enable, ifid_write, ifid_flush, idex_bubble, pipe_stall};
  endfunction

  localparam logic [5:0] C_IDLE   = 6'b000110;
  localparam logic [5:0] C_NORMAL = 6'b011000;
  localparam logic [5:0] C_MISS   = 6'b100001;
  localparam logic [5:0] C_BRANCH = 6'b011110;
  localparam logic [5:0] C_LU     = 6'b000010;

  // Advance one edge; inputs are changed and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hazards();
    mem_stall = 1'b0; branch = 1'b0; memread = 1'b0;
    idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; clear_hazards();
    step(); step();
    checks++;
    if (ctrl() !== C_IDLE) begin
      failures++; $display("FAIL reset_ctrl got=%b want=%b", ctrl(), C_IDLE);
    end
    checks++;
    if ({lu_cnt, flush_cnt, miss_cyc} !== 48'd0) begin
      failures++; $display("FAIL reset_cnt got=%0d/%0d/%0d want=0/0/0", lu_cnt, flush_cnt, miss_cyc);
    end
    rst = 1'b0; #1;
    checks++;
    if (ctrl() !== C_IDLE) begin
      failures++; $display("FAIL idle_after_release got=%b want=%b", ctrl(), C_IDLE);
    end
    step();
    checks++;
    if (ctrl() !== C_NORMAL) begin
      failures++; $display("FAIL run_first_edge got=%b want=%b", ctrl(), C_NORMAL);
    end
    $display("T1 reset done");
  endtask

  task automatic test_load_use();
    memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; ifid_rt = 5'd3; #1;
    checks++;
    if (ctrl() !== C_LU) begin
      failures++; $display("FAIL lu_rs_ctrl got=%b want=%b", ctrl(), C_LU);
    end
    step(); clear_hazards(); #1;
    checks++;
    if (lu_cnt !== 16'd1) begin
      failures++; $display("FAIL lu_cnt_1 got=%0d want=1", lu_cnt);
    end
    memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; #1;
    checks++;
    if (ctrl() !== C_NORMAL) begin
      failures++; $display("FAIL lu_r0_ctrl got=%b want=%b", ctrl(), C_NORMAL);
    end
    step();
    checks++;
    if (lu_cnt !== 16'd1) begin
      failures++; $display("FAIL lu_r0_cnt got=%0d want=1", lu_cnt);
    end
    memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd2; ifid_rt = 5'd5; #1;
    checks++;
    if (ctrl() !== C_LU) begin
      failures++; $display("FAIL lu_rt_ctrl got=%b want=%b", ctrl(), C_LU);
    end
    memread = 1'b0; #1;
    checks++;
    if (ctrl() !== C_NORMAL) begin
      failures++; $display("FAIL lu_noload_ctrl got=%b want=%b", ctrl(), C_NORMAL);
    end
    memread = 1'b1; step(); clear_hazards(); #1;
    checks++;
    if (lu_cnt !== 16'd2) begin
      failures++; $display("FAIL lu_cnt_2 got=%0d want=2", lu_cnt);
    end
    $display("T2 load-use done lu_cnt=%0d", lu_cnt);
  endtask

  task automatic test_branch();
    memread = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; branch = 1'b1; #1;
    checks++;
    if (ctrl() !== C_BRANCH) begin
      failures++; $display("FAIL branch_ctrl got=%b want=%b", ctrl(), C_BRANCH);
    end
    step(); clear_hazards(); #1;
    checks++;
    if (flush_cnt !== 16'd1 || lu_cnt !== 16'd2) begin
      failures++; $display("FAIL branch_cnt got=%0d/%0d want flush=1 lu=2", flush_cnt, lu_cnt);
    end
    $display("T3 branch done flush_cnt=%0d", flush_cnt);
  endtask

  task automatic test_miss();
    mem_stall = 1'b1; branch = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++;
      if (ctrl() !== C_MISS) begin
        failures++; $display("FAIL miss_ctrl_c%0d got=%b want=%b", i + 1, ctrl(), C_MISS);
      end
      step();
    end
    checks++;
    if (miss_cyc !== 16'd7 || flush_cnt !== 16'd1) begin
      failures++; $display("FAIL miss_cnt got=%0d flush=%0d want 7/1", miss_cyc, flush_cnt);
    end
    mem_stall = 1'b0; #1;
    checks++;
    if (ctrl() !== C_BRANCH) begin
      failures++; $display("FAIL miss_then_branch got=%b want=%b", ctrl(), C_BRANCH);
    end
    step(); clear_hazards(); #1;
    checks++;
    if (flush_cnt !== 16'd2 || miss_cyc !== 16'd7) begin
      failures++; $display("FAIL after_miss_cnt got flush=%0d miss=%0d want 2/7", flush_cnt, miss_cyc);
    end
    $display("T4 miss done miss_cyc=%0d flush_cnt=%0d", miss_cyc, flush_cnt);
  endtask

  task automatic test_stop_mid_miss();
    mem_stall = 1'b1;
    step(); step();
    start = 1'b0;            // miss cycle 3: not counted, IDLE next edge
    step();
    checks++;
    if (ctrl() !== C_IDLE) begin
      failures++; $display("FAIL stop_idle got=%b want=%b", ctrl(), C_IDLE);
    end
    checks++;
    if (miss_cyc !== 16'd9) begin
      failures++; $display("FAIL stop_miss_cnt got=%0d want=9", miss_cyc);
    end
    start = 1'b1; mem_stall = 1'b0;
    step();
    mem_stall = 1'b1;
    step(); step();
    rst = 1'b1;
    step();
    checks++;
    if (ctrl() !== C_IDLE || {lu_cnt, flush_cnt, miss_cyc} !== 48'd0) begin
      failures++; $display("FAIL rst_mid_miss got=%b cnt=%0d/%0d/%0d want=%b 0/0/0",
                           ctrl(), lu_cnt, flush_cnt, miss_cyc, C_IDLE);
    end
    rst = 1'b0; mem_stall = 1'b0;
    step();
    checks++;
    if (ctrl() !== C_NORMAL) begin
      failures++; $display("FAIL rst_recover got=%b want=%b", ctrl(), C_NORMAL);
    end
    $display("T5 stop/reset mid-miss done");
  endtask

  task automatic test_saturation();
    mem_stall = 1'b1;
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (s_miss_cyc !== 4'd15 || miss_cyc !== 16'd20) begin
      failures++; $display("FAIL sat_20 got small=%0d big=%0d want 15/20", s_miss_cyc, miss_cyc);
    end
    step(); step();
    checks++;
    if (s_miss_cyc !== 4'd15) begin
      failures++; $display("FAIL sat_hold got=%0d want=15", s_miss_cyc);
    end
    clear_hazards();
    $display("T6 saturation done small_miss=%0d", s_miss_cyc);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_miss();
    test_stop_mid_miss();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
